// File: rtl/apb_master_if.sv
// apb_master_if: command/response channel plus APB bus for apb_master.
// The master modport is the apb_master view; slave is the environment view.
interface apb_master_if #(
   parameter int         AWIDTH = 10,
   parameter logic [2:0] DSIZE  = 3'd2
);
   localparam int DBYTES = 1 << DSIZE;
   localparam int DWIDTH = DBYTES * 8;

   // command channel
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [AWIDTH-1:0] cmd_addr;
   logic [DWIDTH-1:0] cmd_wdata;
   logic [DBYTES-1:0] cmd_strb;
   logic [2:0]        cmd_prot;

   // response channel
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DWIDTH-1:0] rsp_rdata;
   logic              rsp_err;

   // APB bus
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [2:0]        pprot;
   logic [AWIDTH-1:0] paddr;
   logic [DBYTES-1:0] pstrb;
   logic [DWIDTH-1:0] pwdata;
   logic [DWIDTH-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      input  rsp_ready, prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output psel, penable, pwrite, pprot, paddr, pstrb, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      output rsp_ready, prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  psel, penable, pwrite, pprot, paddr, pstrb, pwdata
   );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding command to APB transfer bridge.
// Optional ACCESS timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
   parameter int         AWIDTH  = 10,
   parameter logic [2:0] DSIZE   = 3'd2,
   parameter int         TIMEOUT = 16
) (
   input  logic         pclk,
   input  logic         preset,
   apb_master_if.master bus
);
   localparam int DBYTES = 1 << DSIZE;
   localparam int DWIDTH = DBYTES * 8;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   if (TIMEOUT < 1) begin : g_timeout_range
      $error("apb_master: TIMEOUT must be at least 1");
   end

   state_t            state;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [2:0]        pprot_q;
   logic [AWIDTH-1:0] paddr_q;
   logic [DBYTES-1:0] pstrb_q;
   logic [DWIDTH-1:0] pwdata_q;
   logic              rsp_valid_q;
   logic [DWIDTH-1:0] rsp_rdata_q;
   logic              rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int              CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0]              stall_cnt;
`endif

   // Command acceptance is the only combinational output.
   assign bus.cmd_ready = (state == IDLE);

   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.pprot     = pprot_q;
   assign bus.paddr     = paddr_q;
   assign bus.pstrb     = pstrb_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   // Transfer sequencer: state plus every registered bus/response output.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state       <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pprot_q     <= '0;
         paddr_q     <= '0;
         pstrb_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         stall_cnt   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  pwrite_q  <= bus.cmd_write;
                  paddr_q   <= bus.cmd_addr;
                  pwdata_q  <= bus.cmd_wdata;
                  pstrb_q   <= bus.cmd_write ? bus.cmd_strb : '0;
                  pprot_q   <= bus.cmd_prot;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  state     <= SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                  stall_cnt <= '0;
`endif
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               // pready wins over an expiring timeout on the same cycle.
               if (bus.pready) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                  rsp_err_q   <= bus.pslverr;
                  state       <= RESP;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (stall_cnt == LAST) begin
                  stall_cnt   <= stall_cnt + 1'b1;
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  state       <= RESP;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter AWIDTH, default 10, meaning address width in bits.
REQ-002 SHALL have parameter DSIZE [2:0], default 2, meaning data size in bytes as log2.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles with pready low; it is used only when APB_MASTER_TIMEOUT_EN is defined.
REQ-004 SHALL have hidden parameters DBYTES = 1<<DSIZE and DWIDTH = DBYTES*8.
REQ-005 Ports (one clock; reset is asynchronous and active-high):
- pclk  in  1  clock
- preset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AWIDTH  byte address
- cmd_wdata  in  DWIDTH  write data
- cmd_strb  in  DBYTES  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DWIDTH  read data
- rsp_err  out  1  error (pslverr or timeout)
- psel, penable, pwrite  out  1  APB controls
- pprot  out  3  APB protection
- paddr  out  AWIDTH  APB address
- pstrb  out  DBYTES  APB strobes
- pwdata  out  DWIDTH  APB write data
- prdata  in  DWIDTH  APB read data
- pready, pslverr  in  1  APB completion and error

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-007 SHALL drive cmd_ready=1 only in IDLE; cmd_valid&cmd_ready SHALL register write/addr/wdata/strb/prot and move the FSM to SETUP.
REQ-008 In SETUP, SHALL drive psel=1 and penable=0 for exactly one cycle, then move to ACCESS.
REQ-009 In ACCESS, SHALL drive psel=1 and penable=1 and hold all APB outputs stable until pready=1.
REQ-010 On ACCESS with pready=1, SHALL capture prdata for a read (0 for a write) into rsp_rdata and pslverr into rsp_err, then move to RESP with psel=penable=0.
REQ-011 In RESP, SHALL hold rsp_valid=1 and stable rsp_* until rsp_ready=1, then move to IDLE.
REQ-012 rsp_ready=1 outside RESP SHALL have no effect.
REQ-013 SHALL drive pstrb=0 for reads and the registered cmd_strb for writes.
REQ-014 SHALL drive paddr verbatim with no alignment applied.
REQ-015 In IDLE and RESP, psel and penable SHALL be 0; pwrite/paddr/pwdata/pstrb/pprot values there are don't-care but SHALL be registered, not combinational from cmd_*.
REQ-016 Minimum latency SHALL be: command accepted at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3 when pready=1 at cycle 2.
REQ-017 Minimum command-to-command period SHALL be 4 cycles when rsp_ready is held 1.
REQ-018 All outputs SHALL be registered except cmd_ready, which is decoded from the state.

Reset
REQ-019 preset=1 SHALL force IDLE immediately, independent of pclk.
REQ-020 Reset values SHALL be psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and cmd_ready=1 after release.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer with no response; the first command after release SHALL start a fresh SETUP.

Configuration
REQ-022 With macro APB_MASTER_TIMEOUT_EN defined, SHALL count ACCESS cycles with pready=0 in a counter of width $clog2(TIMEOUT+1), cleared on entry to SETUP.
REQ-023 With APB_MASTER_TIMEOUT_EN defined, when the count reaches TIMEOUT, SHALL end the transfer (psel=penable=0), set rsp_err=1 and rsp_rdata=0, and move to RESP.
REQ-024 With APB_MASTER_TIMEOUT_EN defined, pready=1 on the same cycle the count reaches TIMEOUT SHALL complete normally with pslverr reported.
REQ-025 Without APB_MASTER_TIMEOUT_EN, SHALL wait in ACCESS indefinitely, and no counter logic SHALL be present.

Verification
REQ-026 Write addr=0x010, wdata=0xDEADBEEF, strb=0xF, pready tied 1 -> SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3 with rsp_err=0; apb_ram word 4 = 0xDEADBEEF.
REQ-027 Write strb=0x3, data=0x11223344 to a word holding 0 -> apb_ram word reads back 0x00003344; a read issues pstrb=0.
REQ-028 Read with pready low for 5 ACCESS cycles and prdata=0xCAFEF00D -> rsp_rdata=0xCAFEF00D, rsp_err=0, all APB outputs stable throughout ACCESS.
REQ-029 pslverr=1 with pready=1, and rsp_ready held 0 for 3 cycles -> rsp_valid and rsp_err=1 held stable for 3 cycles, cmd_ready=0 throughout.
REQ-030 APB_MASTER_TIMEOUT_EN defined, TIMEOUT=16, pready stuck 0 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; with the macro undefined, psel stays 1 for 100 cycles.
REQ-031 preset pulsed during ACCESS -> psel=penable=0 asynchronously, rsp_valid=0, and the next command completes normally.
